// File: rtl/ifetch.sv
// Fetch stage: issues in-order word requests, buffers up to two instructions. Macro IFETCH_MISALIGN_TRAP_EN adds fetch_misaligned.
// Latency: request at N, response at N+k, instr_valid at N+k+1; outputs are registered FIFO head.
// Backpressure: stall holds the head; requests stop once buffered + in-flight would exceed two entries.
module ifetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  entry_t          fifo_q [2];
  entry_t          fifo_d [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic [1:0]      outstanding_q, outstanding_d;
  logic [1:0]      discard_q, discard_d;
  logic [XLEN-1:0] tag_q [2];
  logic [XLEN-1:0] tag_d [2];
  logic            tag_rd_q, tag_rd_d;

  logic            fetch_blocked;
  logic [XLEN-1:0] redirect_tgt;
  entry_t          head;
  logic            pop, req_fire, resp_fire, resp_keep;
  logic [2:0]      occupancy;
  logic            fifo_widx, tag_widx;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  // A misaligned target is kept verbatim so the trap handler sees the faulting PC.
  assign redirect_tgt     = redirect_pc;
  assign fetch_blocked    = mis_q;
  assign fetch_misaligned = mis_q;

  always_comb begin
    mis_d = mis_q;
    if (redirect) mis_d = |redirect_pc[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end
`else
  assign redirect_tgt  = redirect_pc & ALIGN_MASK;
  assign fetch_blocked = 1'b0;
`endif

  assign head        = fifo_q[rd_ptr_q];
  assign instr_valid = (count_q != 2'd0);
  assign instr       = instr_valid ? head.instr : NOP;
  assign pc          = instr_valid ? head.pc : {XLEN{1'b0}};

  // A slot freed by this cycle's pop counts as credit, giving one fetch per cycle at k = 1.
  assign pop            = instr_valid && !stall && !redirect;
  assign occupancy      = {1'b0, count_q} + {1'b0, outstanding_q} - {2'b00, pop};
  assign imem_req_valid = !redirect && !fetch_blocked && (occupancy < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_fire      = imem_resp_valid && (outstanding_q != 2'd0);
  assign resp_keep      = resp_fire && (discard_q == 2'd0) && !redirect;
  assign fifo_widx      = rd_ptr_q ^ count_q[0];
  assign tag_widx       = tag_rd_q ^ outstanding_q[0];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    tag_d         = tag_q;
    tag_rd_d      = tag_rd_q ^ resp_fire;
    if (redirect) begin
      fetch_pc_d    = redirect_tgt;
      count_d       = 2'd0;
      outstanding_d = outstanding_q - {1'b0, resp_fire};
      discard_d     = outstanding_q - {1'b0, resp_fire};
    end else begin
      if (req_fire) begin
        fetch_pc_d      = fetch_pc_q + PC_STEP;
        tag_d[tag_widx] = fetch_pc_q;
      end
      outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, resp_fire};
      if (resp_fire && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
      if (resp_keep) begin
        fifo_d[fifo_widx].pc    = tag_q[tag_rd_q];
        fifo_d[fifo_widx].instr = imem_resp_data;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, resp_keep} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      tag_q[0]      <= '0;
      tag_q[1]      <= '0;
      tag_rd_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      tag_q         <= tag_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

endmodule
